// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
`timescale 1ns/1ps
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_I = 2'd1,
        ACC_D = 2'd2
    } arb_state_t;

    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned STAT_W           = 32;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and shared memory port of the arbiter.
`timescale 1ns/1ps
interface mem_arbiter_if #(
    parameter int unsigned WORD_SIZE = 32
);
    logic                 if_req;
    logic [WORD_SIZE-1:0] if_addr;
    logic                 if_valid;
    logic [WORD_SIZE-1:0] if_rdata;

    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic                 d_valid;
    logic [WORD_SIZE-1:0] d_rdata;

    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_valid, if_rdata, d_valid, d_rdata, mem_we, mem_addr, mem_wdata
    );

    // Requesters plus memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_valid, if_rdata, d_valid, d_rdata, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_stats.sv
// Grant and conflict event counters, present only with MEM_ARBITER_STATS_EN.
`timescale 1ns/1ps
module mem_arbiter_stats
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_grant_i,
    input  logic              i_grant_d,
    input  logic              i_conflict,
    output logic [STAT_W-1:0] o_if_grants,
    output logic [STAT_W-1:0] o_d_grants,
    output logic [STAT_W-1:0] o_conflicts
);
    logic [STAT_W-1:0] r_if_grants;
    logic [STAT_W-1:0] r_d_grants;
    logic [STAT_W-1:0] r_conflicts;

    // Counters wrap naturally at 2^STAT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_grants <= '0;
            r_d_grants  <= '0;
            r_conflicts <= '0;
        end else begin
            if (i_grant_i)  r_if_grants <= r_if_grants + STAT_W'(1);
            if (i_grant_d)  r_d_grants  <= r_d_grants + STAT_W'(1);
            if (i_conflict) r_conflicts <= r_conflicts + STAT_W'(1);
        end
    end

    assign o_if_grants = r_if_grants;
    assign o_d_grants  = r_d_grants;
    assign o_conflicts = r_conflicts;
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single memory port, data priority
// with a starvation bound for fetch. Optional counters: MEM_ARBITER_STATS_EN.
`timescale 1ns/1ps
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_arbiter_if.slave      bus
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_if_grants,
    output logic [STAT_W-1:0] stat_d_grants,
    output logic [STAT_W-1:0] stat_conflicts
`endif
);
    localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    arb_state_t           r_state;
    logic [STREAK_W-1:0]  r_streak;
    logic                 r_mem_we;
    logic [WORD_SIZE-1:0] r_mem_addr;
    logic [WORD_SIZE-1:0] r_mem_wdata;
    logic                 r_if_valid;
    logic                 r_d_valid;
    logic [WORD_SIZE-1:0] r_if_rdata;
    logic [WORD_SIZE-1:0] r_d_rdata;

    logic                 w_idle;
    logic                 w_grant_d;
    logic                 w_grant_i;

    // Data wins a tie unless fetch has already been passed over STARVE_LIMIT times.
    assign w_idle    = (r_state == IDLE);
    assign w_grant_d = w_idle && bus.d_req && (!bus.if_req || (r_streak != STREAK_MAX));
    assign w_grant_i = w_idle && bus.if_req && !w_grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_streak    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_if_valid <= 1'b0;
                    r_d_valid  <= 1'b0;
                    if (w_grant_d) begin
                        r_state     <= ACC_D;
                        r_mem_addr  <= bus.d_addr;
                        r_mem_we    <= bus.d_we;
                        r_mem_wdata <= bus.d_wdata;
                        if (bus.if_req && (r_streak != STREAK_MAX))
                            r_streak <= r_streak + STREAK_W'(1);
                    end else if (w_grant_i) begin
                        r_state    <= ACC_I;
                        r_mem_addr <= bus.if_addr;
                        r_mem_we   <= 1'b0;
                        r_streak   <= '0;
                    end
                end
                ACC_I: begin
                    r_state    <= IDLE;
                    r_if_rdata <= bus.mem_rdata;
                    r_if_valid <= 1'b1;
                    r_mem_we   <= 1'b0;
                end
                ACC_D: begin
                    // Async-read memory: mem_rdata here is the pre-store word.
                    r_state   <= IDLE;
                    r_d_rdata <= bus.mem_rdata;
                    r_d_valid <= 1'b1;
                    r_mem_we  <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_valid  = r_if_valid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_valid   = r_d_valid;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

`ifdef MEM_ARBITER_STATS_EN
    logic w_conflict;
    assign w_conflict = w_idle && bus.if_req && bus.d_req;

    mem_arbiter_stats u_stats (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_grant_i   (w_grant_i),
        .i_grant_d   (w_grant_d),
        .i_conflict  (w_conflict),
        .o_if_grants (stat_if_grants),
        .o_d_grants  (stat_d_grants),
        .o_conflicts (stat_conflicts)
    );
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter with a behavioural memory.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int unsigned WS = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_load = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.WORD_SIZE(WS)) bus ();

`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] st_i, st_d, st_c;
`endif

    mem_arbiter #(.WORD_SIZE(WS), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .stat_if_grants (st_i),
        .stat_d_grants  (st_d),
        .stat_conflicts (st_c)
`endif
    );

    // 64-word memory, async read, posedge write, address wraps
    logic [31:0] mem [64];
    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            mem[4] <= 32'hDEAD_BEEF;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] exp_if;
        logic [31:0] exp_d;
        logic        exp_d_first;
    } vec_t;

    vec_t vt [9];

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    // Called at a negedge; drives one vector and follows it to completion.
    task automatic run_vec(input vec_t v, input int id);
        logic pend_i, pend_d, first_seen, first_d;
        int cyc, lat, wecnt, spurious;
        string tag;
        tag = $sformatf("v%0d", id);
        bus.if_req = v.if_req; bus.if_addr = v.if_addr;
        bus.d_req = v.d_req; bus.d_we = v.d_we; bus.d_addr = v.d_addr; bus.d_wdata = v.d_wdata;
        pend_i = v.if_req; pend_d = v.d_req;
        first_seen = 1'b0; first_d = 1'b0;
        cyc = 0; lat = 0; wecnt = 0; spurious = 0;
        while ((pend_i || pend_d) && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_we) wecnt++;
            if (cyc == 1)
                chk({tag, "_acc_addr"}, bus.mem_addr, v.exp_d_first ? v.d_addr : v.if_addr);
            if (bus.d_valid) begin
                if (pend_d) begin
                    if (!first_seen) begin first_seen = 1'b1; first_d = 1'b1; lat = cyc; end
                    chk({tag, "_d_rdata"}, bus.d_rdata, v.exp_d);
                    pend_d = 1'b0; bus.d_req = 1'b0;
                end else spurious++;
            end
            if (bus.if_valid) begin
                if (pend_i) begin
                    if (!first_seen) begin first_seen = 1'b1; first_d = 1'b0; lat = cyc; end
                    chk({tag, "_if_rdata"}, bus.if_rdata, v.exp_if);
                    pend_i = 1'b0; bus.if_req = 1'b0;
                end else spurious++;
            end
        end
        chk({tag, "_timeout"}, 32'(pend_i | pend_d), 32'd0);
        chk({tag, "_winner_d"}, 32'(first_d), 32'(v.exp_d_first));
        chk({tag, "_latency"}, 32'(lat), 32'd2);
        chk({tag, "_store_cycles"}, 32'(wecnt), (v.d_req && v.d_we) ? 32'd1 : 32'd0);
        chk({tag, "_spurious_valid"}, 32'(spurious), 32'd0);
        idle_inputs();
    endtask

    initial begin
        vec_t vr;
        int g, cyc, dv_seen;
        logic exp_grant_d;

        //            if_req if_addr       d_req we  d_addr        d_wdata       exp_if        exp_d         d_first
        vt[0] = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0,       32'h0,        32'hDEAD_BEEF, 32'h0,        1'b0};
        vt[1] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0,      32'hA000_0008, 1'b1};
        vt[2] = '{1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0,       32'h0,        32'h1234_5678, 32'h0,        1'b0};
        vt[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0020, 32'h0,      32'h0,         32'h1234_5678, 1'b1};
        vt[4] = '{1'b1, 32'h0000_0024, 1'b1, 1'b0, 32'h0000_0028, 32'h0,      32'hA000_0009, 32'hA000_000A, 1'b1};
        vt[5] = '{1'b1, 32'h0000_0020, 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h1234_5678, 1'b1};
        vt[6] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hFFFF_FF00, 32'h0,      32'h0,         32'hA000_0000, 1'b1};
        vt[7] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0030, 32'hFFFF_FFFF, 32'h0,      32'hA000_000C, 1'b1};
        vt[8] = '{1'b1, 32'h0000_0030, 1'b0, 1'b0, 32'h0,       32'h0,        32'hA000_000C, 32'h0,        1'b0};

        idle_inputs();
        repeat (3) @(negedge clk);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_d_valid", 32'(bus.d_valid), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        rst_n = 1'b1;
        mem_load = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vt[i], i);

        // Reset asserted in the middle of a store
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_003C; bus.d_wdata = 32'h5555_5555;
        @(negedge clk);
        chk("mid_store_we_before", 32'(bus.mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("mid_store_we_async", 32'(bus.mem_we), 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        dv_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.d_valid) dv_seen++;
        end
        chk("mid_store_no_valid", 32'(dv_seen), 32'd0);
        chk("mid_store_mem", mem[15], 32'hA000_000F);
        vr = '{1'b1, 32'h0000_003C, 1'b0, 1'b0, 32'h0, 32'h0, 32'hA000_000F, 32'h0, 1'b0};
        run_vec(vr, 9);

        // Both requesters held continuously from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0004;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0008;
        g = 0; cyc = 0;
        while (g < 10 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.d_valid || bus.if_valid) begin
                exp_grant_d = ((g % 5) != 4);
                chk($sformatf("starve_grant%0d_d", g), 32'(bus.d_valid), 32'(exp_grant_d));
                chk($sformatf("starve_grant%0d_i", g), 32'(bus.if_valid), 32'(!exp_grant_d));
                g++;
            end
        end
        idle_inputs();
        chk("starve_timeout", 32'(g), 32'd10);
`ifdef MEM_ARBITER_STATS_EN
        chk("stat_d_grants", st_d, 32'd8);
        chk("stat_if_grants", st_i, 32'd2);
        chk("stat_conflicts", st_c, 32'd10);
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
